// File: rtl/cl_manycore_pkg.sv
// cl_manycore_pkg: AXI4-Lite bus bundles, response codes and guard FSM states
package cl_manycore_pkg;
  typedef struct packed {
    logic [31:0] awaddr;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        rready;
  } axil_mosi_s;
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } axil_miso_s;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} axil_resp_e;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_e;
endpackage

// File: rtl/cl_ocl_axil_timer.sv
// cl_ocl_axil_timer: response-wait timer with expiry strobe and saturating expiry count
module cl_ocl_axil_timer #(
  parameter int TIMEOUT_CYC_P = 4096
) (
  input  logic        clk_main_a0,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        run,
  input  logic        done,
  output logic        expire,
  output logic [15:0] events
);
  localparam int TW = $clog2(TIMEOUT_CYC_P) + 1;
  logic [TW-1:0] t;
  // a response landing on the last cycle pre-empts the timeout
  assign expire = run && !done && t == TW'(TIMEOUT_CYC_P - 1);
  always_ff @(posedge clk_main_a0 or negedge rst_n)
    if (!rst_n) begin
      t      <= '0;
      events <= '0;
    end else begin
      t <= clear ? '0 : run ? t + 1'b1 : t;
      if (expire && events != 16'hFFFF) events <= events + 1'b1;
    end
endmodule

// File: rtl/cl_ocl_axil_guard.sv
// cl_ocl_axil_guard: registered AXI4-Lite guard between shell OCL and manycore,
// answering SLVERR when the downstream never responds
module cl_ocl_axil_guard
  import cl_manycore_pkg::*;
#(
  parameter int          TIMEOUT_CYC_P = 4096,
  parameter logic [31:0] ERR_RDATA_P   = 32'hDEAD_BEEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  axil_mosi_s  s_axil_i,
  output axil_miso_s  s_axil_o,
  output axil_mosi_s  m_axil_o,
  input  axil_miso_s  m_axil_i,
  output logic [15:0] wr_timeout_cnt_o,
  output logic [15:0] rd_timeout_cnt_o,
  output logic        timeout_sticky_o
);
  logic [1:0] rst_sync;
  logic rst_n;
  wr_state_e wr_state;
  rd_state_e rd_state;
  logic aw_held, w_held, m_awvalid, m_wvalid, s_bvalid, wr_drain, wr_exp;
  logic m_arvalid, s_rvalid, rd_drain, rd_exp;
  logic [31:0] awaddr, wdata, araddr, s_rdata;
  logic [3:0] wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic aw_hs, w_hs, ar_hs;
  always_ff @(posedge clk_main_a0 or negedge rst_main_n)
    if (!rst_main_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  always_comb begin
    s_axil_o = '{awready: rst_n && wr_state == W_IDLE && !aw_held,
                 wready:  rst_n && wr_state == W_IDLE && !w_held,
                 bresp: s_bresp, bvalid: s_bvalid,
                 arready: rst_n && rd_state == R_IDLE,
                 rdata: s_rdata, rresp: s_rresp, rvalid: s_rvalid};
    m_axil_o = '{awaddr: awaddr, awvalid: m_awvalid, wdata: wdata, wstrb: wstrb,
                 wvalid: m_wvalid, bready: wr_state == W_WAIT || wr_drain,
                 araddr: araddr, arvalid: m_arvalid,
                 rready: rd_state == R_WAIT || rd_drain};
  end
  assign aw_hs = s_axil_o.awready && s_axil_i.awvalid;
  assign w_hs  = s_axil_o.wready && s_axil_i.wvalid;
  assign ar_hs = s_axil_o.arready && s_axil_i.arvalid;
  cl_ocl_axil_timer #(.TIMEOUT_CYC_P(TIMEOUT_CYC_P)) u_wr_timer (
    .clk_main_a0(clk_main_a0), .rst_n(rst_n), .clear(wr_state != W_WAIT),
    .run(wr_state == W_WAIT), .done(m_axil_i.bvalid), .expire(wr_exp),
    .events(wr_timeout_cnt_o));
  cl_ocl_axil_timer #(.TIMEOUT_CYC_P(TIMEOUT_CYC_P)) u_rd_timer (
    .clk_main_a0(clk_main_a0), .rst_n(rst_n), .clear(rd_state != R_WAIT),
    .run(rd_state == R_WAIT), .done(m_axil_i.rvalid), .expire(rd_exp),
    .events(rd_timeout_cnt_o));
  always_ff @(posedge clk_main_a0 or negedge rst_n)
    if (!rst_n) timeout_sticky_o <= 1'b0;
    else if (wr_exp || rd_exp) timeout_sticky_o <= 1'b1;
  always_ff @(posedge clk_main_a0 or negedge rst_n)
    if (!rst_n) begin
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= OKAY;
      wr_drain  <= 1'b0;
    end else begin
      if (wr_drain && m_axil_i.bvalid) wr_drain <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr  <= s_axil_i.awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            wdata  <= s_axil_i.wdata;
            wstrb  <= s_axil_i.wstrb;
            w_held <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            if (wr_drain) begin
              s_bvalid <= 1'b1;
              s_bresp  <= SLVERR;
              wr_state <= W_RESP;
            end else begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              wr_state  <= W_ISSUE;
            end
          end
        end
        W_ISSUE: begin
          if (m_axil_i.awready) m_awvalid <= 1'b0;
          if (m_axil_i.wready) m_wvalid <= 1'b0;
          if ((!m_awvalid || m_axil_i.awready) && (!m_wvalid || m_axil_i.wready)) wr_state <= W_WAIT;
        end
        W_WAIT:
          if (m_axil_i.bvalid || wr_exp) begin
            s_bvalid <= 1'b1;
            s_bresp  <= m_axil_i.bvalid ? m_axil_i.bresp : SLVERR;
            wr_drain <= !m_axil_i.bvalid;
            wr_state <= W_RESP;
          end
        default:
          if (s_axil_i.bready) begin
            s_bvalid <= 1'b0;
            wr_state <= W_IDLE;
          end
      endcase
    end
  always_ff @(posedge clk_main_a0 or negedge rst_n)
    if (!rst_n) begin
      rd_state  <= R_IDLE;
      araddr    <= '0;
      m_arvalid <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rresp   <= OKAY;
      s_rdata   <= '0;
      rd_drain  <= 1'b0;
    end else begin
      if (rd_drain && m_axil_i.rvalid) rd_drain <= 1'b0;
      case (rd_state)
        R_IDLE:
          if (ar_hs) begin
            araddr <= s_axil_i.araddr;
            if (rd_drain) begin
              s_rvalid <= 1'b1;
              s_rresp  <= SLVERR;
              s_rdata  <= ERR_RDATA_P;
              rd_state <= R_RESP;
            end else begin
              m_arvalid <= 1'b1;
              rd_state  <= R_ISSUE;
            end
          end
        R_ISSUE:
          if (m_axil_i.arready) begin
            m_arvalid <= 1'b0;
            rd_state  <= R_WAIT;
          end
        R_WAIT:
          if (m_axil_i.rvalid || rd_exp) begin
            s_rvalid <= 1'b1;
            s_rresp  <= m_axil_i.rvalid ? m_axil_i.rresp : SLVERR;
            s_rdata  <= m_axil_i.rvalid ? m_axil_i.rdata : ERR_RDATA_P;
            rd_drain <= !m_axil_i.rvalid;
            rd_state <= R_RESP;
          end
        default:
          if (s_axil_i.rready) begin
            s_rvalid <= 1'b0;
            rd_state <= R_IDLE;
          end
      endcase
    end
endmodule
